// File: rtl/dbus_master_arbiter.sv
// dbus_master_arbiter
//   Two-master round-robin arbiter for the SoC data bus. Master 0 is the CPU
//   data port and master 1 is the DMA engine. A single slave port feeds the
//   memory_arbiter address decoder. One transaction is in flight at a time.
//   It stays locked until the slave acknowledges it or the timeout expires.
//
// Ports
//   clk, rst          clock, synchronous active-low reset
//   mX_req            request; payload held stable until mX_ready
//   mX_addr/wdata/rw  request payload (rw: 1 = write, 0 = read)
//   mX_rdata          registered read data
//   mX_ready          one-cycle completion pulse
//   mX_err            timeout error, qualifies mX_ready
//   s_valid           slave request, held until s_ready or timeout
//   s_addr/wdata/rw   latched payload of the granted master
//   s_rdata, s_ready  slave response
//   gnt_id            id of the master currently or last granted
//   busy              FSM is not idle
module dbus_master_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 200
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_rw,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ready,
  output logic          m0_err,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_rw,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ready,
  output logic          m1_err,
  output logic          s_valid,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  output logic          s_rw,
  input  logic [DW-1:0] s_rdata,
  input  logic          s_ready,
  output logic          gnt_id,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state, state_nxt;
  logic [TO_W-1:0] to_cnt;
  logic            to_flag;
  logic            grant;
  logic            winner;
  logic            done_ok;
  logic            done_to;

  // Arbitration and WAIT exit conditions. A tie goes to the master that was
  // not granted last; s_ready on the final cycle still counts as success.
  always_comb begin
    grant   = (state == IDLE) && (m0_req || m1_req);
    winner  = (m0_req && m1_req) ? ~gnt_id : m1_req;
    done_ok = (state == WAIT) && s_ready;
    done_to = (state == WAIT) && !s_ready && (to_cnt == TO_LAST);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = WAIT;
      WAIT:    if (done_ok || done_to) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latched payload, grant id, timeout counter and read-data capture
  always_ff @(posedge clk) begin
    if (!rst) begin
      gnt_id   <= 1'b1;
      s_addr   <= '0;
      s_wdata  <= '0;
      s_rw     <= 1'b0;
      to_cnt   <= '0;
      to_flag  <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else if (grant) begin
      gnt_id  <= winner;
      s_addr  <= winner ? m1_addr  : m0_addr;
      s_wdata <= winner ? m1_wdata : m0_wdata;
      s_rw    <= winner ? m1_rw    : m0_rw;
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else if (state == WAIT) begin
      to_cnt <= to_cnt + TO_W'(1);
      if (done_to) to_flag <= 1'b1;
      if (done_ok && !s_rw) begin
        if (gnt_id) m1_rdata <= s_rdata;
        else        m0_rdata <= s_rdata;
      end
    end
  end

  // Outputs decoded from state; err is only ever visible alongside ready
  always_comb begin
    s_valid  = (state == WAIT);
    busy     = (state != IDLE);
    m0_ready = (state == RESP) && !gnt_id;
    m1_ready = (state == RESP) &&  gnt_id;
    m0_err   = m0_ready && to_flag;
    m1_err   = m1_ready && to_flag;
  end

endmodule

// File: tb/tb_dbus_master_arbiter.sv
module tb_dbus_master_arbiter;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TO_W    = 8;
  localparam int TIMEOUT = 200;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          m0_req = 1'b0, m1_req = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic          m0_rw = 1'b0, m1_rw = 1'b0;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          m0_ready, m1_ready, m0_err, m1_err;
  logic          s_valid, s_rw, s_ready = 1'b0;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata, s_rdata = '0;
  logic          gnt_id, busy;

  dbus_master_arbiter #(.AW(AW), .DW(DW), .TO_W(TO_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rw(m0_rw),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rw(m1_rw),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready), .m1_err(m1_err),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_rw(s_rw),
    .s_rdata(s_rdata), .s_ready(s_ready), .gnt_id(gnt_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Transaction-level reference: pending requests per master, last grant,
  // and the read data each master should currently see.
  logic          pend [2];
  logic [AW-1:0] p_addr [2];
  logic [DW-1:0] p_wdata [2];
  logic          p_rw [2];
  logic          exp_gnt;
  logic [DW-1:0] exp_rdata [2];
  int unsigned   rcnt [2];
  logic          last_w;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    m0_req = pend[0]; m0_addr = p_addr[0]; m0_wdata = p_wdata[0]; m0_rw = p_rw[0];
    m1_req = pend[1]; m1_addr = p_addr[1]; m1_wdata = p_wdata[1]; m1_rw = p_rw[1];
  endtask

  task automatic new_txn(input int i, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic rw);
    pend[i] = 1'b1; p_addr[i] = a; p_wdata[i] = wd; p_rw[i] = rw;
  endtask

  function automatic logic rdy_of(input logic i);
    return i ? m1_ready : m0_ready;
  endfunction

  function automatic logic err_of(input logic i);
    return i ? m1_err : m0_err;
  endfunction

  task automatic chk_rdata(input string tag);
    chk({tag, "_rd0"}, 64'(m0_rdata), 64'(exp_rdata[0]));
    chk({tag, "_rd1"}, 64'(m1_rdata), 64'(exp_rdata[1]));
  endtask

  // Serve one arbitration slot starting in IDLE. d = WAIT cycle index (0-based)
  // on which the slave answers; negative means it never answers.
  task automatic serve(input int d, input logic [DW-1:0] rd);
    logic w;
    logic ok;
    int   k;
    drive();
    s_ready = 1'($urandom_range(0, 1));   // must be ignored in IDLE
    s_rdata = $urandom;
    if (!pend[0] && !pend[1]) begin
      tick();
      chk("idle_valid", 64'(s_valid), 64'(0));
      chk("idle_busy", 64'(busy), 64'(0));
      chk("idle_gnt", 64'(gnt_id), 64'(exp_gnt));
      return;
    end
    w = (pend[0] && pend[1]) ? ~exp_gnt : pend[1];
    tick();
    exp_gnt = w;
    last_w  = w;
    chk("grant_valid", 64'(s_valid), 64'(1));
    chk("grant_gnt", 64'(gnt_id), 64'(w));
    chk("grant_addr", 64'(s_addr), 64'(p_addr[w]));
    chk("grant_wdata", 64'(s_wdata), 64'(p_wdata[w]));
    chk("grant_rw", 64'(s_rw), 64'(p_rw[w]));
    chk("grant_nordy", 64'({m0_ready, m1_ready}), 64'(0));
    k = 0;
    ok = 1'b0;
    forever begin
      s_ready = (k == d);
      s_rdata = (k == d) ? rd : DW'($urandom);
      tick();
      if (k == d) begin ok = 1'b1; break; end
      if (k == TIMEOUT - 1) break;
      if (k % 16 == 0 || k >= TIMEOUT - 3) begin
        chk("wait_valid", 64'(s_valid), 64'(1));
        chk("wait_addr", 64'(s_addr), 64'(p_addr[w]));
        chk("wait_wdata", 64'(s_wdata), 64'(p_wdata[w]));
        chk("wait_rw", 64'(s_rw), 64'(p_rw[w]));
        chk("wait_nordy", 64'({m0_ready, m1_ready}), 64'(0));
      end
      k++;
    end
    if (ok && !p_rw[w]) exp_rdata[w] = rd;
    chk("resp_valid", 64'(s_valid), 64'(0));
    chk("resp_ready", 64'(rdy_of(w)), 64'(1));
    chk("resp_err", 64'(err_of(w)), 64'(!ok));
    chk("resp_other", 64'({rdy_of(~w), err_of(~w)}), 64'(0));
    chk_rdata("resp");
    if (rdy_of(w)) rcnt[w]++;
    pend[w] = 1'b0;
    drive();
    s_ready = 1'($urandom_range(0, 1));   // must be ignored in RESP
    tick();
    chk("post_ready", 64'({m0_ready, m1_ready, m0_err, m1_err}), 64'(0));
    chk("post_valid", 64'(s_valid), 64'(0));
    chk("post_busy", 64'(busy), 64'(0));
    chk_rdata("post");
  endtask

  function automatic int pick_delay();
    int r;
    r = int'($urandom_range(0, 9));
    if (r <= 6) return int'($urandom_range(0, 5));
    if (r == 7) return TIMEOUT - 1;
    if (r == 8) return -1;
    return int'($urandom_range(6, 30));
  endfunction

  initial begin
    pend[0] = 1'b0; pend[1] = 1'b0;
    p_addr[0] = '0; p_addr[1] = '0; p_wdata[0] = '0; p_wdata[1] = '0;
    p_rw[0] = 1'b0; p_rw[1] = 1'b0;
    exp_gnt = 1'b1; exp_rdata[0] = '0; exp_rdata[1] = '0;
    rcnt[0] = 0; rcnt[1] = 0; last_w = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_valid", 64'(s_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_gnt", 64'(gnt_id), 64'(1));
    chk("rst_ready", 64'({m0_ready, m1_ready, m0_err, m1_err}), 64'(0));
    chk("rst_saddr", 64'(s_addr), 64'(0));
    chk("rst_swdata", 64'(s_wdata), 64'(0));
    chk("rst_srw", 64'(s_rw), 64'(0));
    chk_rdata("rst");
    rst = 1'b1;

    // m0 read, slave answers one cycle after s_valid
    new_txn(0, 32'h0000_0010, 32'h0, 1'b0);
    serve(1, 32'hCAFE_0001);
    chk("t1_rdata", 64'(m0_rdata), 64'h0000_0000_CAFE_0001);

    // m1 write, slave answers on the fifth WAIT cycle
    new_txn(1, 32'h4000_0004, 32'h1234_5678, 1'b1);
    serve(4, 32'hDEAD_BEEF);
    chk("t3_rdata", 64'(m1_rdata), 64'(0));

    // Slave never answers: timeout after TIMEOUT WAIT cycles
    new_txn(0, 32'h0000_0020, 32'h0, 1'b0);
    serve(-1, 32'h0);
    chk("t4_rdata", 64'(m0_rdata), 64'h0000_0000_CAFE_0001);

    // Slave answers on the last possible cycle: success wins
    new_txn(0, 32'h0000_0030, 32'h0, 1'b0);
    serve(TIMEOUT - 1, 32'h5A5A_0005);
    chk("t5_rdata", 64'(m0_rdata), 64'h0000_0000_5A5A_0005);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0)
          new_txn(i, $urandom, $urandom, 1'($urandom_range(0, 1)));
        else if (pend[i] && $urandom_range(0, 7) == 0)
          pend[i] = 1'b0;
      end
      serve(pick_delay(), $urandom);
    end

    // Reset in the middle of WAIT
    new_txn(0, 32'h0000_0040, 32'h0, 1'b0);
    pend[1] = 1'b0;
    drive();
    s_ready = 1'b0;
    tick();
    chk("mid_valid", 64'(s_valid), 64'(1));
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("mid_rst_valid", 64'(s_valid), 64'(0));
    chk("mid_rst_ready", 64'({m0_ready, m1_ready}), 64'(0));
    chk("mid_rst_gnt", 64'(gnt_id), 64'(1));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    rst = 1'b1;
    exp_gnt = 1'b1; exp_rdata[0] = '0; exp_rdata[1] = '0;
    chk_rdata("mid_rst");

    // Both masters request continuously: grants alternate starting with m0
    rcnt[0] = 0; rcnt[1] = 0;
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i]) new_txn(i, $urandom, $urandom, 1'($urandom_range(0, 1)));
      serve(int'($urandom_range(0, 3)), $urandom);
      chk("fair_seq", 64'(last_w), 64'(n % 2));
    end
    chk("fair_cnt0", 64'(rcnt[0]), 64'(2));
    chk("fair_cnt1", 64'(rcnt[1]), 64'(2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
